stall_controller: RTL and testbench

Central pipeline stall/flush sequencer for the 5-stage MIPS pipeline. It combines three sources into one consistent set of pipeline-register controls: load-use hazards in ID, taken branches resolved in ID, and multi-cycle data-memory accesses in MEM. A small FSM with a watchdog counter holds the whole pipeline frozen while a data-memory access is outstanding. Sits beside the hazard unit and drives the PC, IF/ID, ID/EX, EX/MEM and MEM/WB write enables.

---
 rtl/stall_controller.sv | 165 ++++++++++++++++
 tb/tb_stall_controller.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/stall_controller.sv
// Pipeline stall/flush sequencer for a 5-stage MIPS pipeline. It merges
// load-use hazards, ID-stage taken branches and multi-cycle data-memory
// accesses into the PC, IF/ID, ID/EX, EX/MEM and MEM/WB register controls.
// Latency: all outputs are combinational from inputs and state (0 cycles).
// Backpressure: an outstanding memory access freezes every pipeline
// register. A watchdog releases the freeze after TIMEOUT cycles.
//
// Parameters: TIMEOUT (2..65535) is the longest MEM_WAIT dwell.
//             CNT_W is the width of the stall performance counter.
// Ports:      clk_i, rst_i (synchronous, active-high)
//             hazard inputs: ID_EX_MEM_Read, ID_EX_RegRt, IF_ID_RegRs, IF_ID_RegRt
//             Branch_Taken, MEM_Req, MEM_Ack
//             outputs: PC_Write, IF_ID_Write, IF_ID_Flush, NOP, ID_EX_Write,
//             EX_MEM_Write, MEM_WB_Write, Mem_Busy, Mem_Err, Stall_Cycles
// Macro:      STALL_CTRL_PERF_EN enables the saturating Stall_Cycles counter.
//             When the macro is undefined, Stall_Cycles is tied to zero.
module stall_controller #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             ID_EX_MEM_Read,
    input  logic [4:0]       ID_EX_RegRt,
    input  logic [4:0]       IF_ID_RegRs,
    input  logic [4:0]       IF_ID_RegRt,
    input  logic             Branch_Taken,
    input  logic             MEM_Req,
    input  logic             MEM_Ack,
    output logic             PC_Write,
    output logic             IF_ID_Write,
    output logic             IF_ID_Flush,
    output logic             NOP,
    output logic             ID_EX_Write,
    output logic             EX_MEM_Write,
    output logic             MEM_WB_Write,
    output logic             Mem_Busy,
    output logic             Mem_Err,
    output logic [CNT_W-1:0] Stall_Cycles
);

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic        mem_err_q, mem_err_d;
    logic        freeze;
    logic        mem_freeze;
    logic        load_use;

    assign mem_freeze = MEM_Req & ~MEM_Ack;

    // Register $zero never carries a real dependency.
    assign load_use = ID_EX_MEM_Read & (ID_EX_RegRt != 5'd0) &
                      ((ID_EX_RegRt == IF_ID_RegRs) | (ID_EX_RegRt == IF_ID_RegRt));

    // Next-state logic. The freeze decision also comes from here because a
    // timeout or an ack releases the pipeline in the same cycle it is seen.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        mem_err_d  = mem_err_q;
        freeze     = 1'b0;
        case (state_q)
            RUN: begin
                if (mem_freeze) begin
                    freeze     = 1'b1;
                    state_d    = MEM_WAIT;
                    wait_cnt_d = 16'd1;
                end
            end
            MEM_WAIT: begin
                if (MEM_Ack || !MEM_Req) begin
                    // A dropped request is treated like an ack.
                    state_d    = RUN;
                    wait_cnt_d = 16'd0;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d    = RUN;
                    wait_cnt_d = 16'd0;
                    mem_err_d  = 1'b1;
                end else begin
                    freeze     = 1'b1;
                    wait_cnt_d = wait_cnt_q + 16'd1;
                end
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = 16'd0;
            end
        endcase
    end

    // Pipeline register controls. Priority: reset, memory freeze, load-use,
    // taken branch. A load-use stall suppresses the branch flush so the
    // branch is re-evaluated once the stalled instruction advances.
    always_comb begin
        PC_Write     = 1'b1;
        IF_ID_Write  = 1'b1;
        IF_ID_Flush  = 1'b0;
        NOP          = 1'b0;
        ID_EX_Write  = 1'b1;
        EX_MEM_Write = 1'b1;
        MEM_WB_Write = 1'b1;
        if (!rst_i) begin
            if (freeze) begin
                PC_Write     = 1'b0;
                IF_ID_Write  = 1'b0;
                ID_EX_Write  = 1'b0;
                EX_MEM_Write = 1'b0;
                MEM_WB_Write = 1'b0;
            end else if (load_use) begin
                PC_Write    = 1'b0;
                IF_ID_Write = 1'b0;
                NOP         = 1'b1;
            end else if (Branch_Taken) begin
                IF_ID_Flush = 1'b1;
            end
        end
    end

    assign Mem_Busy = (state_q == MEM_WAIT) & ~rst_i;
    assign Mem_Err  = mem_err_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= RUN;
            wait_cnt_q <= 16'd0;
            mem_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_d;
        end
    end

`ifdef STALL_CTRL_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // Count each cycle the PC is held. The counter saturates instead of wrapping.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!PC_Write && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign Stall_Cycles = stall_cnt_q;
`else
    assign Stall_Cycles = '0;
`endif

endmodule

// File: tb/tb_stall_controller.sv
// Self-checking bench for stall_controller.
// Directed test-plan sequences with literal expectations are followed by
// randomized traffic. A behavioural model is compared on every cycle.
module tb_stall_controller;

    localparam int TO    = 4;
    localparam int CW    = 4;
    localparam int CMAX  = (1 << CW) - 1;
`ifdef STALL_CTRL_PERF_EN
    localparam int PERF = 1;
`else
    localparam int PERF = 0;
`endif

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          ID_EX_MEM_Read = 1'b0;
    logic [4:0]    ID_EX_RegRt = 5'd0;
    logic [4:0]    IF_ID_RegRs = 5'd0;
    logic [4:0]    IF_ID_RegRt = 5'd0;
    logic          Branch_Taken = 1'b0;
    logic          MEM_Req = 1'b0;
    logic          MEM_Ack = 1'b0;
    logic          PC_Write, IF_ID_Write, IF_ID_Flush, NOP;
    logic          ID_EX_Write, EX_MEM_Write, MEM_WB_Write;
    logic          Mem_Busy, Mem_Err;
    logic [CW-1:0] Stall_Cycles;

    int n_cmp = 0;
    int n_bad = 0;

    stall_controller #(.TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .ID_EX_MEM_Read(ID_EX_MEM_Read), .ID_EX_RegRt(ID_EX_RegRt),
        .IF_ID_RegRs(IF_ID_RegRs), .IF_ID_RegRt(IF_ID_RegRt),
        .Branch_Taken(Branch_Taken), .MEM_Req(MEM_Req), .MEM_Ack(MEM_Ack),
        .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write), .IF_ID_Flush(IF_ID_Flush),
        .NOP(NOP), .ID_EX_Write(ID_EX_Write), .EX_MEM_Write(EX_MEM_Write),
        .MEM_WB_Write(MEM_WB_Write), .Mem_Busy(Mem_Busy), .Mem_Err(Mem_Err),
        .Stall_Cycles(Stall_Cycles)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
        end
    endtask

    // Reference model state. An access is pending after its first frozen
    // cycle. age counts the frozen cycles seen so far for that access.
    bit m_pending = 1'b0;
    int m_age     = 0;
    bit m_err     = 1'b0;
    int m_cnt     = 0;

    bit e_pc, e_ifw, e_fl, e_nop, e_en, e_busy, fz, tmo, lu;

    always @(negedge clk_i) begin
        fz  = 1'b0;
        tmo = 1'b0;
        lu  = ID_EX_MEM_Read && (ID_EX_RegRt != 0) &&
              (ID_EX_RegRt == IF_ID_RegRs || ID_EX_RegRt == IF_ID_RegRt);
        if (rst_i) begin
            {e_pc, e_ifw, e_en, e_fl, e_nop, e_busy} = 6'b111_000;
        end else begin
            e_busy = m_pending;
            if (MEM_Req && !MEM_Ack) begin
                // A pending access is released once TO frozen cycles are used up.
                if (m_pending && m_age >= TO - 1) tmo = 1'b1;
                else fz = 1'b1;
            end
            if (fz)      {e_pc, e_ifw, e_en, e_fl, e_nop} = 5'b000_00;
            else if (lu) {e_pc, e_ifw, e_en, e_fl, e_nop} = 5'b001_01;
            else         {e_pc, e_ifw, e_en, e_fl, e_nop} = {3'b111, Branch_Taken, 1'b0};
        end
        chk("m_PC_Write", PC_Write, e_pc);
        chk("m_IF_ID_Write", IF_ID_Write, e_ifw);
        chk("m_IF_ID_Flush", IF_ID_Flush, e_fl);
        chk("m_NOP", NOP, e_nop);
        chk("m_ID_EX_Write", ID_EX_Write, e_en);
        chk("m_EX_MEM_Write", EX_MEM_Write, e_en);
        chk("m_MEM_WB_Write", MEM_WB_Write, e_en);
        chk("m_Mem_Busy", Mem_Busy, e_busy);
        chk("m_Mem_Err", Mem_Err, m_err);
        chk("m_Stall_Cycles", Stall_Cycles, PERF ? m_cnt : 0);
        if (rst_i) begin
            m_pending = 1'b0; m_age = 0; m_err = 1'b0; m_cnt = 0;
        end else begin
            if (fz) begin
                m_pending = 1'b1; m_age = m_age + 1;
            end else begin
                m_pending = 1'b0; m_age = 0;
            end
            if (tmo) m_err = 1'b1;
            if (!e_pc && m_cnt < CMAX) m_cnt = m_cnt + 1;
        end
    end

    task automatic cyc(input bit r, input bit ld, input int ldrt, input int rs, input int rt,
                       input bit br, input bit rq, input bit ak);
        @(posedge clk_i);
        #1;
        rst_i = r; ID_EX_MEM_Read = ld;
        ID_EX_RegRt = 5'(ldrt); IF_ID_RegRs = 5'(rs); IF_ID_RegRt = 5'(rt);
        Branch_Taken = br; MEM_Req = rq; MEM_Ack = ak;
        @(negedge clk_i);
        #1;
    endtask

    bit req_hold = 1'b0;
    bit r, ld, br, rq, ak;

    initial begin
        // Reset state
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_PC_Write", PC_Write, 1);
        chk("rst_NOP", NOP, 0);
        chk("rst_Mem_Busy", Mem_Busy, 0);
        cyc(1, 0, 0, 0, 0, 0, 1, 0);
        chk("rst_forced_MEM_WB_Write", MEM_WB_Write, 1);
        chk("rst_Mem_Err", Mem_Err, 0);
        chk("rst_Stall_Cycles", Stall_Cycles, 0);

        // Load-use on Rs
        cyc(0, 1, 8, 8, 9, 0, 0, 0);
        chk("lu_PC_Write", PC_Write, 0);
        chk("lu_IF_ID_Write", IF_ID_Write, 0);
        chk("lu_NOP", NOP, 1);
        chk("lu_ID_EX_Write", ID_EX_Write, 1);
        // $zero never stalls
        cyc(0, 1, 0, 0, 9, 0, 0, 0);
        chk("zero_PC_Write", PC_Write, 1);
        chk("zero_NOP", NOP, 0);
        // Taken branch without a hazard
        cyc(0, 0, 0, 1, 2, 1, 0, 0);
        chk("br_IF_ID_Flush", IF_ID_Flush, 1);
        chk("br_IF_ID_Write", IF_ID_Write, 1);
        // Taken branch with a hazard on Rt
        cyc(0, 1, 5, 1, 5, 1, 0, 0);
        chk("brlu_IF_ID_Flush", IF_ID_Flush, 0);
        chk("brlu_NOP", NOP, 1);
        chk("brlu_PC_Write", PC_Write, 0);
        // Zero-wait memory access
        cyc(0, 0, 0, 0, 0, 0, 1, 1);
        chk("zw_PC_Write", PC_Write, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        chk("zw_Mem_Busy", Mem_Busy, 0);

        // Ack 3 cycles after request; a simultaneous hazard loses to the freeze
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 8, 8, 0, 0, 1, 0);
        chk("mf_PC_Write", PC_Write, 0);
        chk("mf_NOP", NOP, 0);
        chk("mf_Mem_Busy0", Mem_Busy, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 0);
        chk("mf_Mem_Busy1", Mem_Busy, 1);
        cyc(0, 0, 0, 0, 0, 0, 1, 0);
        chk("mf_EX_MEM_Write2", EX_MEM_Write, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 1);
        chk("mf_ack_PC_Write", PC_Write, 1);
        chk("mf_ack_Mem_Busy", Mem_Busy, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        chk("mf_after_Mem_Busy", Mem_Busy, 0);
        chk("mf_Stall_Cycles", Stall_Cycles, PERF ? 3 : 0);

        // Watchdog with TO=4: three frozen cycles, released on the fourth
        cyc(0, 0, 0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 0);
        chk("to_frozen_PC_Write", PC_Write, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 0);
        chk("to_release_PC_Write", PC_Write, 1);
        chk("to_release_Mem_Err", Mem_Err, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        chk("to_Mem_Err", Mem_Err, 1);
        chk("to_Mem_Busy", Mem_Busy, 0);

        // Reset during a wait
        cyc(0, 0, 0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 0);
        chk("rw_Mem_Busy", Mem_Busy, 1);
        cyc(1, 0, 0, 0, 0, 0, 1, 0);
        chk("rw_forced_PC_Write", PC_Write, 1);
        chk("rw_forced_Mem_Busy", Mem_Busy, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        chk("rw_Mem_Busy_after", Mem_Busy, 0);
        chk("rw_Mem_Err", Mem_Err, 0);
        chk("rw_Stall_Cycles", Stall_Cycles, 0);

        // Randomized traffic, checked by the model on every cycle
        for (int i = 0; i < 4000; i++) begin
            r  = ($urandom_range(0, 199) == 0);
            ld = ($urandom_range(0, 2) == 0);
            br = ($urandom_range(0, 3) == 0);
            if (req_hold) rq = ($urandom_range(0, 19) != 0);
            else          rq = ($urandom_range(0, 2) == 0);
            ak = rq && ($urandom_range(0, 3) == 0);
            req_hold = rq && !ak;
            cyc(r, ld, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), br, rq, ak);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
